// File: rtl/avalon_mem_bridge.sv
// avalon_mem_bridge: serialises five cache/prefetch request channels onto one 32-bit Avalon-MM burst master
module avalon_mem_bridge (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_writeburst_do,
    output logic         o_writeburst_done,
    input  logic [31:0]  i_writeburst_address,
    input  logic [1:0]   i_writeburst_dword_length,
    input  logic [3:0]   i_writeburst_byteenable_0,
    input  logic [3:0]   i_writeburst_byteenable_1,
    input  logic [55:0]  i_writeburst_data,
    input  logic         i_writeline_do,
    output logic         o_writeline_done,
    input  logic [31:0]  i_writeline_address,
    input  logic [127:0] i_writeline_line,
    input  logic         i_readburst_do,
    output logic         o_readburst_done,
    input  logic [31:0]  i_readburst_address,
    input  logic [1:0]   i_readburst_dword_length,
    input  logic [3:0]   i_readburst_byte_length,
    output logic [95:0]  o_readburst_data,
    input  logic         i_readline_do,
    output logic         o_readline_done,
    input  logic [31:0]  i_readline_address,
    output logic [127:0] o_readline_line,
    input  logic         i_readcode_do,
    output logic         o_readcode_done,
    input  logic [31:0]  i_readcode_address,
    output logic [127:0] o_readcode_line,
    output logic [31:0]  o_readcode_partial,
    output logic         o_readcode_partial_done,
    output logic [31:0]  o_avm_address,
    output logic [31:0]  o_avm_writedata,
    output logic [3:0]   o_avm_byteenable,
    output logic [2:0]   o_avm_burstcount,
    output logic         o_avm_write,
    output logic         o_avm_read,
    input  logic         i_avm_waitrequest,
    input  logic         i_avm_readdatavalid,
    input  logic [31:0]  i_avm_readdata
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
    localparam logic [2:0] C_WB = 3'd0, C_WL = 3'd1, C_RB = 3'd2, C_RL = 3'd3, C_RC = 3'd4;

    state_t        r_state, w_next;
    logic [2:0]    r_src, w_sel;
    logic [1:0]    r_beat, r_last, r_off;
    logic [3:0]    r_blen;
    logic [4:0]    r_done;
    logic          r_rd_cmd, r_pdone, w_go, w_wr_fin, w_rd_fin;
    logic [127:0]  r_wbuf, r_rbuf, w_rnext, r_rl_line, r_rc_line;
    logic [15:0]   r_bebuf;
    logic [31:0]   r_addr, r_partial;
    logic [2:0]    r_bc;
    logic [95:0]   r_rb_data, w_rb_data, w_rb_mask;
    logic [63:0]   w_wb_sh;

    assign w_wb_sh = {8'h00, i_writeburst_data} << {i_writeburst_address[1:0], 3'b000};

    assign o_avm_address           = r_addr;
    assign o_avm_burstcount        = r_bc;
    assign o_avm_writedata         = r_wbuf[31:0];
    assign o_avm_byteenable        = r_bebuf[3:0];
    assign o_avm_write             = (r_state == S_WRITE);
    assign o_avm_read              = (r_state == S_READ) && r_rd_cmd;
    assign o_writeburst_done       = r_done[C_WB];
    assign o_writeline_done        = r_done[C_WL];
    assign o_readburst_done        = r_done[C_RB];
    assign o_readline_done         = r_done[C_RL];
    assign o_readcode_done         = r_done[C_RC];
    assign o_readburst_data        = r_rb_data;
    assign o_readline_line         = r_rl_line;
    assign o_readcode_line         = r_rc_line;
    assign o_readcode_partial      = r_partial;
    assign o_readcode_partial_done = r_pdone;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    // Priority arbitration, completion detection and next state; a pulsing done blocks re-acceptance of the still-held _do
    always_comb begin
        w_sel    = i_writeburst_do ? C_WB : i_writeline_do ? C_WL : i_readburst_do ? C_RB :
                   i_readline_do ? C_RL : C_RC;
        w_go     = (r_state == S_IDLE) && (r_done == 5'd0) &&
                   (i_writeburst_do || i_writeline_do || i_readburst_do || i_readline_do || i_readcode_do);
        w_wr_fin = (r_state == S_WRITE) && !i_avm_waitrequest && (r_beat == r_last);
        w_rd_fin = (r_state == S_READ) && i_avm_readdatavalid && (r_beat == r_last);
        w_next   = w_go ? ((w_sel <= C_WL) ? S_WRITE : S_READ) : (w_wr_fin || w_rd_fin) ? S_IDLE : r_state;
    end

    // Read assembly: drop the incoming beat into its slot, then align and trim the readburst view
    always_comb begin
        w_rnext = r_rbuf;
        w_rnext[{r_beat, 5'b00000} +: 32] = i_avm_readdata;
        w_rb_mask = '0;
        for (int i = 0; i < 12; i++) w_rb_mask[8*i +: 8] = (4'(i) < r_blen) ? 8'hFF : 8'h00;
        w_rb_data = (w_rnext[95:0] >> {r_off, 3'b000}) & w_rb_mask;
    end

    // Datapath: latch the chosen request, shift write beats out, collect read beats, publish results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0; r_beat <= '0; r_last <= '0; r_off <= '0; r_blen <= '0; r_done <= '0;
            r_rd_cmd <= 1'b0; r_pdone <= 1'b0; r_wbuf <= '0; r_rbuf <= '0; r_bebuf <= '0;
            r_addr <= '0; r_bc <= '0; r_partial <= '0; r_rb_data <= '0; r_rl_line <= '0; r_rc_line <= '0;
        end else begin
            r_done  <= (w_wr_fin || w_rd_fin) ? (5'd1 << r_src) : 5'd0;
            r_pdone <= 1'b0;
            if (w_go) begin
                r_src    <= w_sel;
                r_beat   <= 2'd0;
                r_rd_cmd <= (w_sel > C_WL);
                case (w_sel)
                    C_WB: begin
                        r_addr  <= {i_writeburst_address[31:2], 2'b00};
                        r_bc    <= i_writeburst_dword_length[1] ? 3'd2 : 3'd1;
                        r_last  <= i_writeburst_dword_length[1] ? 2'd1 : 2'd0;
                        r_wbuf  <= {64'd0, w_wb_sh};
                        r_bebuf <= {8'h00, i_writeburst_byteenable_1, i_writeburst_byteenable_0};
                    end
                    C_WL: begin
                        r_addr  <= {i_writeline_address[31:4], 4'h0};
                        r_bc    <= 3'd4;
                        r_last  <= 2'd3;
                        r_wbuf  <= i_writeline_line;
                        r_bebuf <= 16'hFFFF;
                    end
                    C_RB: begin
                        r_addr  <= {i_readburst_address[31:2], 2'b00};
                        r_bc    <= {1'b0, (i_readburst_dword_length == 2'd0) ? 2'd1 : i_readburst_dword_length};
                        r_last  <= (i_readburst_dword_length == 2'd0) ? 2'd0 : i_readburst_dword_length - 2'd1;
                        r_off   <= i_readburst_address[1:0];
                        r_blen  <= i_readburst_byte_length;
                        r_bebuf <= 16'hFFFF;
                    end
                    default: begin
                        r_addr  <= {(w_sel == C_RL) ? i_readline_address[31:4] : i_readcode_address[31:4], 4'h0};
                        r_bc    <= 3'd4;
                        r_last  <= 2'd3;
                        r_bebuf <= 16'hFFFF;
                    end
                endcase
            end
            if (r_state == S_WRITE && !i_avm_waitrequest) begin
                r_wbuf  <= r_wbuf >> 32;
                r_bebuf <= r_bebuf >> 4;
                r_beat  <= r_beat + 2'd1;
            end
            if (r_state == S_READ) begin
                if (!i_avm_waitrequest) r_rd_cmd <= 1'b0;
                if (i_avm_readdatavalid) begin
                    r_rbuf <= w_rnext;
                    r_beat <= r_beat + 2'd1;
                    if (r_src == C_RC) begin
                        r_partial <= i_avm_readdata;
                        r_pdone   <= 1'b1;
                    end
                    if (w_rd_fin) begin
                        if (r_src == C_RB) r_rb_data <= w_rb_data;
                        if (r_src == C_RL) r_rl_line <= w_rnext;
                        if (r_src == C_RC) r_rc_line <= w_rnext;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_avalon_mem_bridge.sv
// tb_avalon_mem_bridge: directed checks of arbitration, write/read bursts, stalls and reset abort
module tb_avalon_mem_bridge;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         wb_do = 0, wl_do = 0, rb_do = 0, rl_do = 0, rc_do = 0;
    logic         wb_done, wl_done, rb_done, rl_done, rc_done, rc_pdone;
    logic [31:0]  wb_addr = 0, wl_addr = 0, rb_addr = 0, rl_addr = 0, rc_addr = 0;
    logic [1:0]   wb_len = 0, rb_len = 0;
    logic [3:0]   wb_be0 = 0, wb_be1 = 0, rb_blen = 0;
    logic [55:0]  wb_data = 0;
    logic [127:0] wl_line = 0, rl_line, rc_line;
    logic [95:0]  rb_data;
    logic [31:0]  rc_partial, avm_address, avm_writedata, avm_readdata = 0;
    logic [3:0]   avm_byteenable;
    logic [2:0]   avm_burstcount;
    logic         avm_write, avm_read, avm_waitrequest = 0, avm_readdatavalid = 0;
    logic [4:0]   dones;
    logic [127:0] line1, line3;
    int           n_chk = 0, n_fail = 0;

    assign dones = {wb_done, wl_done, rb_done, rl_done, rc_done};

    always #5 clk = ~clk;

    avalon_mem_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .i_writeburst_do(wb_do), .o_writeburst_done(wb_done), .i_writeburst_address(wb_addr),
        .i_writeburst_dword_length(wb_len), .i_writeburst_byteenable_0(wb_be0),
        .i_writeburst_byteenable_1(wb_be1), .i_writeburst_data(wb_data),
        .i_writeline_do(wl_do), .o_writeline_done(wl_done), .i_writeline_address(wl_addr),
        .i_writeline_line(wl_line),
        .i_readburst_do(rb_do), .o_readburst_done(rb_done), .i_readburst_address(rb_addr),
        .i_readburst_dword_length(rb_len), .i_readburst_byte_length(rb_blen), .o_readburst_data(rb_data),
        .i_readline_do(rl_do), .o_readline_done(rl_done), .i_readline_address(rl_addr), .o_readline_line(rl_line),
        .i_readcode_do(rc_do), .o_readcode_done(rc_done), .i_readcode_address(rc_addr), .o_readcode_line(rc_line),
        .o_readcode_partial(rc_partial), .o_readcode_partial_done(rc_pdone),
        .o_avm_address(avm_address), .o_avm_writedata(avm_writedata), .o_avm_byteenable(avm_byteenable),
        .o_avm_burstcount(avm_burstcount), .o_avm_write(avm_write), .o_avm_read(avm_read),
        .i_avm_waitrequest(avm_waitrequest), .i_avm_readdatavalid(avm_readdatavalid), .i_avm_readdata(avm_readdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        line1 = 128'h88887777_66665555_44443333_22221111;
        line3 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        @(negedge clk);
        tick;
        rst_n = 1'b1;
        tick;
        chk("reset write", avm_write, 0);
        chk("reset read", avm_read, 0);
        chk("reset dones", dones, 0);
        chk("reset partial_done", rc_pdone, 0);

        // writeline, no stalls
        wl_do = 1; wl_addr = 32'h0101; wl_line = line1;
        tick;
        chk("wl address", avm_address, 32'h100);
        chk("wl burstcount", avm_burstcount, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wl write", avm_write, 1);
            chk("wl data", avm_writedata, line1[32*i +: 32]);
            chk("wl be", avm_byteenable, 4'hF);
            chk("wl addr hold", avm_address, 32'h100);
            tick;
        end
        chk("wl done", dones, 5'b01000);
        chk("wl write drop", avm_write, 0);
        wl_do = 0;
        tick;
        chk("wl done single", dones, 0);

        // writeburst, unaligned two beats
        wb_do = 1; wb_addr = 32'h0101; wb_len = 2; wb_be0 = 4'hF; wb_be1 = 4'h5; wb_data = 56'h23456789abcdef;
        tick;
        chk("wb write", avm_write, 1);
        chk("wb address", avm_address, 32'h100);
        chk("wb burstcount", avm_burstcount, 2);
        chk("wb data0", avm_writedata, 32'habcdef00);
        chk("wb be0", avm_byteenable, 4'hF);
        tick;
        chk("wb data1", avm_writedata, 32'h23456789);
        chk("wb be1", avm_byteenable, 4'h5);
        chk("wb burstcount hold", avm_burstcount, 2);
        tick;
        chk("wb done", dones, 5'b10000);
        chk("wb write drop", avm_write, 0);
        wb_do = 0;
        tick;
        chk("wb done single", dones, 0);

        // writeline with a 3-cycle stall on beat 1
        wl_do = 1; wl_addr = 32'h0300; wl_line = line3;
        tick;
        chk("stall beat0", avm_writedata, line3[31:0]);
        tick;
        chk("stall beat1", avm_writedata, line3[63:32]);
        avm_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall data hold", avm_writedata, line3[63:32]);
            chk("stall addr hold", avm_address, 32'h300);
            chk("stall be hold", avm_byteenable, 4'hF);
            chk("stall write hold", avm_write, 1);
            chk("stall no done", dones, 0);
        end
        avm_waitrequest = 0;
        tick;
        chk("stall beat2", avm_writedata, line3[95:64]);
        tick;
        chk("stall beat3", avm_writedata, line3[127:96]);
        chk("stall done early", dones, 0);
        tick;
        chk("stall done", dones, 5'b01000);
        wl_do = 0;
        tick;

        // readline with readdatavalid gaps
        rl_do = 1; rl_addr = 32'h2000;
        tick;
        chk("rl read", avm_read, 1);
        chk("rl address", avm_address, 32'h2000);
        chk("rl burstcount", avm_burstcount, 4);
        chk("rl be", avm_byteenable, 4'hF);
        tick;
        chk("rl read drop", avm_read, 0);
        avm_readdatavalid = 1; avm_readdata = 1;
        tick;
        avm_readdatavalid = 0;
        tick;
        avm_readdatavalid = 1; avm_readdata = 2;
        tick;
        avm_readdata = 3;
        tick;
        avm_readdatavalid = 0;
        chk("rl done early", dones, 0);
        tick;
        tick;
        avm_readdatavalid = 1; avm_readdata = 4;
        tick;
        avm_readdatavalid = 0;
        chk("rl done", dones, 5'b00010);
        chk("rl line", rl_line, {32'd4, 32'd3, 32'd2, 32'd1});
        rl_do = 0;
        tick;
        chk("rl done single", dones, 0);

        // readburst: offset 2, 2 beats, 5 valid bytes
        rb_do = 1; rb_addr = 32'h4002; rb_len = 2; rb_blen = 5;
        tick;
        chk("rb read", avm_read, 1);
        chk("rb address", avm_address, 32'h4000);
        chk("rb burstcount", avm_burstcount, 2);
        tick;
        avm_readdatavalid = 1; avm_readdata = 32'h44332211;
        tick;
        avm_readdata = 32'h88776655;
        tick;
        avm_readdatavalid = 0;
        chk("rb done", dones, 5'b00100);
        chk("rb data", rb_data, 96'h00000000_00000077_66554433);
        rb_do = 0;
        tick;

        // simultaneous writeburst and readcode: writeburst first
        wb_do = 1; wb_addr = 32'h200; wb_len = 0; wb_be0 = 4'hF; wb_data = 56'h11223344;
        rc_do = 1; rc_addr = 32'h3010;
        tick;
        chk("prio write", avm_write, 1);
        chk("prio read", avm_read, 0);
        chk("prio wb burstcount", avm_burstcount, 1);
        chk("prio wb data", avm_writedata, 32'h11223344);
        tick;
        chk("prio wb done", dones, 5'b10000);
        wb_do = 0;
        tick;
        chk("prio gap", dones, 0);
        tick;
        chk("rc read", avm_read, 1);
        chk("rc address", avm_address, 32'h3010);
        chk("rc burstcount", avm_burstcount, 4);
        tick;
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1; avm_readdata = 32'hC0DE0000 + 32'(i);
            tick;
            chk("rc partial_done", rc_pdone, 1);
            chk("rc partial", rc_partial, 32'hC0DE0000 + 32'(i));
            if (i < 3) chk("rc done early", dones, 0);
        end
        avm_readdatavalid = 0;
        chk("rc done", dones, 5'b00001);
        chk("rc line", rc_line, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
        chk("rl line hold", rl_line, {32'd4, 32'd3, 32'd2, 32'd1});
        rc_do = 0;
        tick;
        chk("rc partial_done drop", rc_pdone, 0);

        // reset mid-transaction aborts without done
        wl_do = 1; wl_addr = 32'h500; wl_line = line1;
        tick;
        tick;
        chk("abort pre write", avm_write, 1);
        rst_n = 0;
        #1;
        chk("abort write", avm_write, 0);
        chk("abort dones", dones, 0);
        wl_do = 0;
        tick;
        rst_n = 1;
        tick;
        chk("abort post write", avm_write, 0);
        chk("abort post dones", dones, 0);
        chk("abort line cleared", rl_line, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
